tube_bcd_latch: RTL

TUBE_BCD_LATCH -- requirements
Module: tube_bcd_latch

---
 rtl/tube_pkg.sv | 25 ++
 rtl/bin2bcd_seq.sv | 68 ++++++
 rtl/tube_bcd_latch.sv | 75 +++++++
 3 files changed

// File: rtl/tube_pkg.sv
// tube_pkg: shared register codes, converter state encoding and constants
// for the tube display latch.
package tube_pkg;

    localparam logic        SEL_VALUE = 1'b0;
    localparam logic        SEL_CTRL  = 1'b1;
    localparam logic [31:0] BCD_MAX   = 32'd99_999_999;
    localparam logic [31:0] ERR_PAT   = 32'hEEEE_EEEE;
    localparam int          ITER      = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    // Double-dabble pre-shift correction applied to all eight BCD nibbles.
    function automatic logic [31:0] dabble_adj(input logic [31:0] b);
        logic [31:0] r;
        for (int i = 0; i < 8; i++)
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative 32-bit binary to 8-digit BCD converter, one
// double-dabble step per cycle; start restarts, abort cancels.
module bin2bcd_seq
    import tube_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] bin,
    output logic [31:0] bcd,
    output logic        ovr,
    output logic        done,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] sh_q, sh_d;
    logic        ovr_q, ovr_d;
    logic        busy_q, busy_d;
    logic [31:0] adj;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        ovr_d   = ovr_q;
        adj     = dabble_adj(sh_q[63:32]);
        if (start) begin
            state_d = ST_SHIFT;
            cnt_d   = 5'd0;
            sh_d    = {32'd0, bin};
            ovr_d   = bin > BCD_MAX;
        end else if (abort) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_SHIFT) begin
            sh_d    = {adj[30:0], sh_q[31:0], 1'b0};
            cnt_d   = cnt_q + 5'd1;
            state_d = (cnt_q == 5'(ITER - 1)) ? ST_COMMIT : ST_SHIFT;
        end else if (state_q == ST_COMMIT) begin
            state_d = ST_IDLE;
        end
        busy_d = state_d != ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            sh_q    <= 64'd0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign bcd  = sh_q[63:32];
    assign ovr  = ovr_q;
    assign done = state_q == ST_COMMIT;
    assign busy = busy_q;

endmodule

// File: rtl/tube_bcd_latch.sv
// tube_bcd_latch: CPU-writable tube display register; decimal display
// mode is compiled in only when TUBE_BCD_EN is defined.
module tube_bcd_latch
    import tube_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        io_write,
    input  logic        tube_cs,
    input  logic        addr_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] tube_num,
    output logic        tube_en
);

    logic        value_we, ctrl_we;
    logic [31:0] raw_q, raw_d, num_q, num_d;
    logic        en_q, en_d, dec_q, dec_d;

    assign value_we = io_write & tube_cs & (addr_sel == SEL_VALUE);
    assign ctrl_we  = io_write & tube_cs & (addr_sel == SEL_CTRL);

`ifdef TUBE_BCD_EN
    logic [31:0] bcd;
    logic        ovr, done;

    // A value write in decimal mode restarts; a hex write cancels.
    bin2bcd_seq u_conv (
        .clock (clock),
        .reset (reset),
        .start (value_we & dec_q),
        .abort (value_we & ~dec_q),
        .bin   (wdata),
        .bcd   (bcd),
        .ovr   (ovr),
        .done  (done),
        .busy  (busy)
    );
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        raw_d = value_we ? wdata : raw_q;
        en_d  = ctrl_we ? wdata[0] : en_q;
`ifdef TUBE_BCD_EN
        dec_d = ctrl_we ? wdata[1] : dec_q;
        num_d = value_we ? (dec_q ? num_q : wdata) : done ? (ovr ? ERR_PAT : bcd) : num_q;
`else
        dec_d = 1'b0;
        num_d = value_we ? wdata : num_q;
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            raw_q <= 32'd0;
            num_q <= 32'd0;
            en_q  <= 1'b0;
            dec_q <= 1'b0;
        end else begin
            raw_q <= raw_d;
            num_q <= num_d;
            en_q  <= en_d;
            dec_q <= dec_d;
        end
    end

    assign rdata    = (addr_sel == SEL_CTRL) ? {29'd0, busy, dec_q, en_q} : raw_q;
    assign tube_num = num_q;
    assign tube_en  = en_q;

endmodule
